// File: rtl/simple_pkg.sv
// Shared types and constants for simple_capture: FIFO states and sample layout.
package simple_pkg;

    localparam int unsigned SMP_W    = 3;
    localparam int unsigned OUT_IDX  = 0;
    localparam int unsigned OUT2_IDX = 1;
    localparam int unsigned OUT3_IDX = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/simple_capture.sv
// Captures samples of the "simple" netlist outputs into a 2-entry FIFO and counts per-bit toggles.
// Optional out2/out3 consistency check enabled by defining SIMPLE_CAPTURE_CHECK_EN.
module simple_capture
    import simple_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                out_i,
    input  logic                out2_i,
    input  logic                out3_i,
    output logic                cap_valid,
    input  logic                cap_ready,
    output logic [SMP_W-1:0]    cap_data,
    input  logic                clr,
    output logic [CNT_W-1:0]    tog0,
    output logic [CNT_W-1:0]    tog1,
    output logic [CNT_W-1:0]    tog2,
    output logic                err
);

    state_e             state_q, state_d;
    logic [SMP_W-1:0]   head_q, head_d;
    logic [SMP_W-1:0]   tail_q, tail_d;
    logic [SMP_W-1:0]   last_q;
    logic               in_ready_q;
    logic               cap_valid_q;
    logic [SMP_W-1:0]   smp;
    logic [SMP_W-1:0]   tog_inc;
    logic               push;
    logic               pop;

    assign smp  = {out3_i, out2_i, out_i};
    assign push = in_valid & in_ready_q;
    assign pop  = cap_valid_q & cap_ready;

    // Next-state and FIFO storage update; head is always the oldest held sample.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = smp;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = smp;
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = smp;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            last_q      <= '0;
            in_ready_q  <= 1'b1;
            cap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != TWO);
            cap_valid_q <= (state_d != EMPTY);
            if (push) begin
                last_q <= smp;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign cap_valid = cap_valid_q;
    assign cap_data  = head_q;

    // A bit toggles when an accepted sample differs from the previously accepted one.
    assign tog_inc = {SMP_W{push}} & (smp ^ last_q);

    sat_counter #(.W(CNT_W)) u_tog0 (
        .clk   (clk),
        .rst   (rst),
        .inc_i (tog_inc[OUT_IDX]),
        .clr_i (clr),
        .cnt_o (tog0)
    );

    sat_counter #(.W(CNT_W)) u_tog1 (
        .clk   (clk),
        .rst   (rst),
        .inc_i (tog_inc[OUT2_IDX]),
        .clr_i (clr),
        .cnt_o (tog1)
    );

    sat_counter #(.W(CNT_W)) u_tog2 (
        .clk   (clk),
        .rst   (rst),
        .inc_i (tog_inc[OUT3_IDX]),
        .clr_i (clr),
        .cnt_o (tog2)
    );

`ifdef SIMPLE_CAPTURE_CHECK_EN
    // out2 and out3 invert the same net, so any disagreement is a sticky fault.
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && (out2_i != out3_i)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simple_capture.sv
// Randomized scoreboard bench for simple_capture with directed reset/FIFO/saturation/err scenarios.
module tb_simple_capture;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_i = 1'b0;
    logic             out2_i = 1'b0;
    logic             out3_i = 1'b0;
    logic             cap_valid;
    logic             cap_ready = 1'b0;
    logic [2:0]       cap_data;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] tog0;
    logic [CNT_W-1:0] tog1;
    logic [CNT_W-1:0] tog2;
    logic             err;

    simple_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_i     (out_i),
        .out2_i    (out2_i),
        .out3_i    (out3_i),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .clr       (clr),
        .tog0      (tog0),
        .tog1      (tog1),
        .tog2      (tog2),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model state, owned by the stimulus process.
    logic [2:0]  exp_q[$];
    int unsigned m_tog[3];
    logic [2:0]  m_last;
    logic        m_err;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced at the edge the DUT sees it.
    task automatic drive(input logic v, input logic [2:0] s, input logic rdy,
                         input logic c, input logic r);
        logic acc;
        in_valid  = v;
        out_i     = s[0];
        out2_i    = s[1];
        out3_i    = s[2];
        cap_ready = rdy;
        clr       = c;
        rst       = r;
        acc = !r && v && (exp_q.size() < 2);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) m_tog[i] = 0;
            m_last = 3'b000;
            m_err  = 1'b0;
        end else begin
            if (acc) begin
                exp_q.push_back(s);
                for (int i = 0; i < 3; i++)
                    if (s[i] != m_last[i] && m_tog[i] < MAXC) m_tog[i]++;
                m_last = s;
`ifdef SIMPLE_CAPTURE_CHECK_EN
                if (s[1] != s[2]) m_err = 1'b1;
`endif
            end
            if (c) for (int i = 0; i < 3; i++) m_tog[i] = 0;
        end
        #1;
    endtask

    // Monitor: compares every observable output against the model once per cycle.
    initial begin : monitor
        logic prev_rst;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_rst) check("reset cap_data", int'(cap_data), 0);
            check("in_ready",  int'(in_ready),  int'(exp_q.size() < 2));
            check("cap_valid", int'(cap_valid), int'(exp_q.size() > 0));
            check("tog0", int'(tog0), int'(m_tog[0]));
            check("tog1", int'(tog1), int'(m_tog[1]));
            check("tog2", int'(tog2), int'(m_tog[2]));
            check("err",  int'(err),  int'(m_err));
            if (cap_valid) begin
                if (exp_q.size() == 0) begin
                    check("cap_valid with empty model", 1, 0);
                end else begin
                    check("cap_data", int'(cap_data), int'(exp_q[0]));
                    if (cap_ready && !rst) void'(exp_q.pop_front());
                end
            end
            prev_rst = rst;
        end
    end

    initial begin : stimulus
        m_last = 3'b000;
        m_err  = 1'b0;
        for (int i = 0; i < 3; i++) m_tog[i] = 0;

        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

        // First sample after reset: bits that are 1 count as toggles.
        drive(1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Fill to TWO with consumer stalled; third push must be dropped.
        drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Simultaneous push and pop while in ONE.
        drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Clear together with a push: counters end at 0, last sample still tracked.
        drive(1'b1, 3'b110, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Saturation: alternate out for 20 pushes after a fresh reset.
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            drive(1'b1, {2'b00, 1'(i % 2 == 0)}, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Consistency error is sticky across good samples until reset.
        drive(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // Reset in TWO with clr and push active.
        drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(9, 0) < 7),
                  3'($urandom_range(7, 0)),
                  1'($urandom_range(9, 0) < 6),
                  1'($urandom_range(15, 0) == 0),
                  1'($urandom_range(99, 0) == 0));
        end
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
